// File: rtl/spi_divmmc_target_pkg.sv
// Shared types and constants for the SD/MMC-style SPI target.
package spi_divmmc_target_pkg;

  typedef enum logic {ST_IDLE, ST_ACTIVE} tgt_state_t;

  localparam logic [7:0] DEFAULT_FILL = 8'hFF;
  localparam int         BIT_CNT_W    = 3;

endpackage : spi_divmmc_target_pkg

// File: rtl/spi_divmmc_target_if.sv
// Host-side byte handshake between the SPI target and card-emulation logic.
// The target uses the slave modport; the card-emulation side uses master.
interface spi_divmmc_target_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_full;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ack,
    output tx_data,
    output tx_load,
    input  tx_full
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ack,
    input  tx_data,
    input  tx_load,
    output tx_full
  );

endinterface : spi_divmmc_target_if

// File: rtl/spi_divmmc_target_sync.sv
// Multi-stage synchronizer with rise/fall detection against one extra flop.
// The chain and the history flop are preset to the pin's idle level so that
// leaving reset never produces a spurious edge.
module spi_divmmc_target_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the pin through the synchronizer and keep one cycle of history.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule : spi_divmmc_target_sync

// File: rtl/spi_divmmc_target.sv
// SPI mode 0 byte-level target emulating an SD/MMC card interface.
// SCK, CS_n and MOSI are oversampled into clk_sys; each SCK phase must last
// at least SYNC_STAGES+2 clk_sys cycles.
// Optional feature: define SPI_DIVMMC_TARGET_OVERRUN_EN to build overrun
// detection (pulse output plus an internal saturating debug counter).
module spi_divmmc_target
  import spi_divmmc_target_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = DEFAULT_FILL
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic spi_cs_n,
  input  logic spi_clk,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic selected,
  output logic sel_start,
  output logic sel_end,
  output logic overrun,
  spi_divmmc_target_if.slave host
);

  // Synchronized pin views
  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  // FSM
  tgt_state_t state, state_next;
  logic       cs_assert, cs_deassert;
  logic       sck_rise_evt, sck_fall_evt;

  // Datapath
  logic [BIT_CNT_W-1:0] bit_cnt, bit_base;
  logic [7:0]           shift_in;
  logic [7:0]           shifter;
  logic [7:0]           hold_reg;
  logic                 tx_full_reg;
  logic [7:0]           rx_data_reg;
  logic                 rx_valid_reg;
  logic                 sel_start_reg, sel_end_reg;
  logic                 reload;
  logic [7:0]           reload_byte;
  logic                 byte_done;
  logic [7:0]           rx_byte;

  spi_divmmc_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .din     (spi_clk),
    .level   (sck_level_unused),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  spi_divmmc_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .din     (spi_cs_n),
    .level   (cs_level_unused),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  // MOSI shares the synchronizer depth so it stays aligned with SCK edges.
  spi_divmmc_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .din     (spi_mosi),
    .level   (mosi_s),
    .rise    (mosi_rise_unused),
    .fall    (mosi_fall_unused)
  );

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state: CS edges alone move between idle and active.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (cs_fall) state_next = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: qualified events for the datapath and the select status.
  // A rising SCK seen together with CS assert is still honoured (CS first);
  // any SCK edge coinciding with CS deassert is dropped with the partial byte.
  always_comb begin
    cs_assert    = (state == ST_IDLE) && cs_fall;
    cs_deassert  = (state == ST_ACTIVE) && cs_rise;
    sck_rise_evt = sck_rise && (((state == ST_ACTIVE) && !cs_rise) || cs_assert);
    sck_fall_evt = sck_fall && (state == ST_ACTIVE) && !cs_rise;
    spi_miso_oe  = (state == ST_ACTIVE);
    selected     = (state == ST_ACTIVE);
  end

  // Bit position used by this cycle's rising edge (CS assert restarts at 0).
  assign bit_base    = cs_assert ? '0 : bit_cnt;
  assign byte_done   = sck_rise_evt && (&bit_base);
  assign rx_byte     = {shift_in[6:0], mosi_s};
  assign reload      = cs_assert || (sck_fall_evt && (bit_cnt == '0));
  assign reload_byte = tx_full_reg ? hold_reg : FILL_BYTE;

  // Receive shifter and bit counter.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      shift_in <= '0;
      bit_cnt  <= '0;
    end else if (cs_deassert) begin
      bit_cnt <= '0;
    end else if (sck_rise_evt) begin
      shift_in <= rx_byte;
      bit_cnt  <= bit_base + 1'b1;
    end else if (cs_assert) begin
      bit_cnt <= '0;
    end
  end

  // Transmit shifter: reload at byte boundaries, shift on other falling edges.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)          shifter <= FILL_BYTE;
    else if (reload)       shifter <= reload_byte;
    else if (sck_fall_evt) shifter <= {shifter[6:0], 1'b0};
  end

  // Holding register: a host load always wins over consumption by the shifter.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg    <= '0;
      tx_full_reg <= 1'b0;
    end else if (host.tx_load) begin
      hold_reg    <= host.tx_data;
      tx_full_reg <= 1'b1;
    end else if (reload && tx_full_reg) begin
      tx_full_reg <= 1'b0;
    end
  end

  // Received byte register: a completing byte beats a simultaneous ack.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else if (byte_done) begin
      rx_data_reg  <= rx_byte;
      rx_valid_reg <= 1'b1;
    end else if (host.rx_ack) begin
      rx_valid_reg <= 1'b0;
    end
  end

  // Select start/end strobes.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sel_start_reg <= 1'b0;
      sel_end_reg   <= 1'b0;
    end else begin
      sel_start_reg <= cs_assert;
      sel_end_reg   <= cs_deassert;
    end
  end

`ifdef SPI_DIVMMC_TARGET_OVERRUN_EN
  logic       overrun_hit;
  logic       overrun_reg;
  logic [7:0] overrun_cnt;

  assign overrun_hit = byte_done && rx_valid_reg && !host.rx_ack;

  // Overrun strobe plus a saturating debug count, cleared per selection.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      overrun_reg <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      overrun_reg <= overrun_hit;
      if (cs_assert)
        overrun_cnt <= '0;
      else if (overrun_hit && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  assign overrun = overrun_reg;
`else
  assign overrun = 1'b0;
`endif

  assign spi_miso      = spi_miso_oe ? shifter[7] : 1'b1;
  assign sel_start     = sel_start_reg;
  assign sel_end       = sel_end_reg;
  assign host.rx_data  = rx_data_reg;
  assign host.rx_valid = rx_valid_reg;
  assign host.tx_full  = tx_full_reg;

endmodule : spi_divmmc_target

// File: tb/tb_spi_divmmc_target.sv
// Testbench for spi_divmmc_target: the bench plays SPI initiator and host.
// Expected received bytes and MISO bytes go into scoreboard queues when the
// stimulus is issued; independent monitors pop and compare.
module tb_spi_divmmc_target;

  localparam logic [7:0] FILL = 8'hFF;
  localparam int         HALF = 4;   // SCK = clk_sys / 8

  logic clk_sys = 1'b0;
  logic reset_n;
  logic spi_cs_n, spi_clk, spi_mosi;
  logic spi_miso, spi_miso_oe, selected, sel_start, sel_end, overrun;

  spi_divmmc_target_if host ();

  spi_divmmc_target dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .spi_cs_n    (spi_cs_n),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .selected    (selected),
    .sel_start   (sel_start),
    .sel_end     (sel_end),
    .overrun     (overrun),
    .host        (host)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  // Scoreboards and reference model state
  logic [7:0] rx_q[$];
  logic [7:0] miso_q[$];
  bit         m_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic [7:0] cur_miso = FILL;
  bit         ack_en = 1'b1;
  bit         rx_pending = 1'b0;
  int         exp_ovr = 0, ovr_seen = 0;
  int         exp_start = 0, start_seen = 0;
  int         exp_end = 0, end_seen = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reply byte chosen at a byte boundary: the held byte if any, else fill.
  function automatic logic [7:0] take();
    logic [7:0] r;
    r = FILL;
    if (m_full) begin
      r      = m_hold;
      m_full = 1'b0;
    end
    return r;
  endfunction

  // Expected receive: without acks a second byte replaces the unread one.
  function automatic void expect_rx(input logic [7:0] b);
    if (!ack_en && rx_pending) begin
      rx_q[rx_q.size()-1] = b;
      exp_ovr++;
    end else begin
      rx_q.push_back(b);
      rx_pending = !ack_en;
    end
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic tx_load_byte(input logic [7:0] v);
    host.tx_data = v;
    host.tx_load = 1'b1;
    @(negedge clk_sys);
    host.tx_load = 1'b0;
    m_hold = v;
    m_full = 1'b1;
    chk("tx_full_load", host.tx_full, 1);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    cur_miso = take();
    exp_start++;
    wait_clk(6);
    chk("selected_on", selected, 1);
    chk("miso_oe_on", spi_miso_oe, 1);
    chk("tx_full_cs", host.tx_full, m_full);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    exp_end++;
    wait_clk(6);
    chk("selected_off", selected, 0);
    chk("miso_oe_off", spi_miso_oe, 0);
  endtask

  // One byte (or a partial byte when nbits<8); optional host load at bit load_bit.
  task automatic xfer(input logic [7:0] b, input int nbits, input bit push_rx,
                      input int load_bit, input logic [7:0] load_val);
    if (nbits == 8) begin
      miso_q.push_back(cur_miso);
      if (push_rx) expect_rx(b);
    end
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      if (i == load_bit) tx_load_byte(load_val);
      wait_clk(HALF);
      spi_clk = 1'b1;
      wait_clk(HALF);
      if (i == 7) chk("tx_full_pre", host.tx_full, m_full);
      spi_clk = 1'b0;
    end
    if (nbits == 8) begin
      cur_miso = take();
      wait_clk(5);
      chk("tx_full_post", host.tx_full, m_full);
    end
  endtask

  // Host consumer: compares every presented byte, then acknowledges it.
  initial begin : rx_monitor
    host.rx_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      host.rx_ack = 1'b0;
      if (reset_n === 1'b1 && ack_en && host.rx_valid === 1'b1) begin
        if (rx_q.size() == 0) begin
          chk("rx_unexpected", host.rx_data, 32'hDEAD);
        end else begin
          $display("rx byte got=%02h exp=%02h", host.rx_data, rx_q[0]);
          chk("rx_data", host.rx_data, rx_q.pop_front());
        end
        host.rx_ack = 1'b1;
      end
    end
  end

  // Initiator-side MISO sampler at each SCK rising edge while selected.
  initial begin : miso_monitor
    int nb;
    logic [7:0] sh;
    nb = 0;
    sh = 8'h00;
    forever begin
      @(posedge spi_clk or posedge spi_cs_n or negedge reset_n);
      if (reset_n !== 1'b1 || spi_cs_n !== 1'b0) begin
        nb = 0;
      end else begin
        sh = {sh[6:0], spi_miso};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (miso_q.size() == 0) begin
            chk("miso_unexpected", sh, 32'hDEAD);
          end else begin
            $display("miso byte got=%02h exp=%02h", sh, miso_q[0]);
            chk("miso_byte", sh, miso_q.pop_front());
          end
        end
      end
    end
  end

  // Pulse counters.
  initial begin : pulse_monitor
    forever begin
      @(negedge clk_sys);
      if (reset_n === 1'b1) begin
        if (sel_start === 1'b1) start_seen++;
        if (sel_end === 1'b1)   end_seen++;
        if (overrun === 1'b1)   ovr_seen++;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int nbytes, lb;
    reset_n      = 1'b0;
    spi_cs_n     = 1'b1;
    spi_clk      = 1'b0;
    spi_mosi     = 1'b0;
    host.tx_data = 8'h00;
    host.tx_load = 1'b0;
    #12;
    chk("rst_rx_data", host.rx_data, 0);
    chk("rst_rx_valid", host.rx_valid, 0);
    chk("rst_tx_full", host.tx_full, 0);
    chk("rst_miso", spi_miso, 1);
    chk("rst_miso_oe", spi_miso_oe, 0);
    chk("rst_selected", selected, 0);
    chk("rst_sel_start", sel_start, 0);
    chk("rst_sel_end", sel_end, 0);
    chk("rst_overrun", overrun, 0);
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(5);

    // Basic exchange
    tx_load_byte(8'hA5);
    cs_low();
    xfer(8'h3C, 8, 1, -1, 8'h00);
    cs_high();

    // Underrun: no reply bytes loaded
    cs_low();
    xfer(8'h00, 8, 1, -1, 8'h00);
    xfer(8'hFF, 8, 1, -1, 8'h00);
    cs_high();

    // CS fall and SCK rise together; no held byte so MISO is all fill
    spi_mosi = 1'b1;            // bit 7 of 8'h96
    spi_cs_n = 1'b0;
    spi_clk  = 1'b1;
    cur_miso = take();
    exp_start++;
    miso_q.push_back(cur_miso);
    expect_rx(8'h96);
    wait_clk(HALF);
    spi_clk = 1'b0;
    for (int i = 1; i < 8; i++) begin
      spi_mosi = (i == 3 || i == 5 || i == 6);
      wait_clk(HALF);
      spi_clk = 1'b1;
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
    cur_miso = take();
    wait_clk(5);
    cs_high();

    // Back-to-back reload with a load during bit 3
    tx_load_byte(8'h01);
    cs_low();
    xfer(8'h12, 8, 1, 3, 8'h80);
    xfer(8'h34, 8, 1, -1, 8'h00);
    cs_high();

    // CS abort after 5 bits, then a fresh byte
    cs_low();
    xfer(8'hE7, 5, 0, -1, 8'h00);
    cs_high();
    cs_low();
    xfer(8'h55, 8, 1, -1, 8'h00);
    cs_high();

    // Two bytes without acknowledgement
    ack_en = 1'b0;
    cs_low();
    xfer(8'h11, 8, 1, -1, 8'h00);
    xfer(8'h22, 8, 1, -1, 8'h00);
    cs_high();
    rx_pending = 1'b0;
    ack_en = 1'b1;
    wait_clk(4);

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 1) == 1) tx_load_byte(8'($urandom));
      cs_low();
      nbytes = $urandom_range(1, 3);
      for (int k = 0; k < nbytes; k++) begin
        lb = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 6));
        xfer(8'($urandom), 8, 1, lb, 8'($urandom));
      end
      if ($urandom_range(0, 3) == 0)
        xfer(8'($urandom), int'($urandom_range(1, 7)), 0, -1, 8'h00);
      cs_high();
    end

    // Reset in the middle of a byte
    tx_load_byte(8'h5A);
    cs_low();
    ack_en = 1'b0;
    xfer(8'h3A, 8, 1, -1, 8'h00);
    tx_load_byte(8'h99);
    xfer(8'h0F, 4, 0, -1, 8'h00);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_rx_data", host.rx_data, 0);
    chk("arst_rx_valid", host.rx_valid, 0);
    chk("arst_tx_full", host.tx_full, 0);
    chk("arst_miso", spi_miso, 1);
    chk("arst_miso_oe", spi_miso_oe, 0);
    chk("arst_selected", selected, 0);
    m_full = 1'b0;
    rx_q.delete();
    rx_pending = 1'b0;
    spi_cs_n = 1'b1;
    spi_clk  = 1'b0;
    wait_clk(3);
    reset_n = 1'b1;
    ack_en  = 1'b1;
    wait_clk(5);
    cs_low();
    xfer(8'hC3, 8, 1, -1, 8'h00);
    cs_high();

    wait_clk(20);
    chk("rx_queue_empty", rx_q.size(), 0);
    chk("miso_queue_empty", miso_q.size(), 0);
    chk("sel_start_count", start_seen, exp_start);
    chk("sel_end_count", end_seen, exp_end);
`ifdef SPI_DIVMMC_TARGET_OVERRUN_EN
    chk("overrun_count", ovr_seen, exp_ovr);
`else
    chk("overrun_count", ovr_seen, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_spi_divmmc_target
